// File: rtl/perf_ctr_pkg.sv
// rtl/perf_ctr_pkg.sv - shared types and helpers for the performance counter bank
// Counter mode enum, channel-count limit and select-width helper.
package perf_ctr_pkg;

   typedef enum logic {
      CTR_WRAP = 1'b0,
      CTR_SAT  = 1'b1
   } ctr_mode_t;

   localparam int MAX_CH = 32;

   function automatic int sel_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/perf_ctr_channel.sv
// rtl/perf_ctr_channel.sv - one rising-edge event counter with sticky overflow
// Edge detect, clear, and wrap/saturate increment for a single channel.
module perf_ctr_channel
   import perf_ctr_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             event_in,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             overflow
);

   localparam ctr_mode_t MODE = (SATURATE != 0) ? CTR_SAT : CTR_WRAP;

   logic             event_q, event_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             rise;

   always_comb begin
      event_d    = event_in;
      rise       = event_in & ~event_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      // A clear swallows any edge arriving in the same cycle.
      if (clear) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (rise && enable) begin
         if (count_q == {WIDTH{1'b1}}) begin
            overflow_d = 1'b1;
            count_d    = (MODE == CTR_SAT) ? count_q : '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_q    <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         event_q    <= event_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/perf_event_counter_bank.sv
// rtl/perf_event_counter_bank.sv - bank of NUM_CH event counters with muxed read port
// Optional shadow snapshot registers are enabled by defining PERF_CTR_SNAPSHOT_EN.
module perf_event_counter_bank
   import perf_ctr_pkg::*;
#(
   parameter int   NUM_CH   = 8,
   parameter int   WIDTH    = 16,
   parameter int   SATURATE = 0,
   localparam int  SEL_W    = sel_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [NUM_CH-1:0] event_in,
   input  logic              clear_all,
   input  logic              clear_ch,
   input  logic [SEL_W-1:0]  clear_sel,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [WIDTH-1:0]  rd_count,
   output logic              rd_overflow,
   output logic [NUM_CH-1:0] overflow_vec,
   input  logic              snapshot_req,
   output logic              snap_valid
);

   logic [WIDTH-1:0]  ch_count [NUM_CH];
   logic [NUM_CH-1:0] ch_ovf;
   logic [NUM_CH-1:0] ch_clear;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Out-of-range clear_sel matches no channel, making clear_ch a no-op.
      assign ch_clear[i] = clear_all | (clear_ch & (int'(clear_sel) == i));

      perf_ctr_channel #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .enable   (enable),
         .event_in (event_in[i]),
         .clear    (ch_clear[i]),
         .count    (ch_count[i]),
         .overflow (ch_ovf[i])
      );
   end

   assign overflow_vec = ch_ovf;

`ifdef PERF_CTR_SNAPSHOT_EN
   logic [WIDTH-1:0]  snap_count_q [NUM_CH];
   logic [WIDTH-1:0]  snap_count_d [NUM_CH];
   logic [NUM_CH-1:0] snap_ovf_q, snap_ovf_d;
   logic              snap_valid_q, snap_valid_d;

   always_comb begin
      snap_count_d = snap_count_q;
      snap_ovf_d   = snap_ovf_q;
      snap_valid_d = snap_valid_q;
      if (clear_all) begin
         for (int i = 0; i < NUM_CH; i++) snap_count_d[i] = '0;
         snap_ovf_d   = '0;
         snap_valid_d = 1'b0;
      end else if (snapshot_req) begin
         snap_count_d = ch_count;
         snap_ovf_d   = ch_ovf;
         snap_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) snap_count_q[i] <= '0;
         snap_ovf_q   <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         snap_count_q <= snap_count_d;
         snap_ovf_q   <= snap_ovf_d;
         snap_valid_q <= snap_valid_d;
      end
   end

   assign snap_valid = snap_valid_q;

   always_comb begin
      rd_count    = '0;
      rd_overflow = 1'b0;
      if (int'(rd_sel) < NUM_CH) begin
         if (snap_valid_q) begin
            rd_count    = snap_count_q[rd_sel];
            rd_overflow = snap_ovf_q[rd_sel];
         end else begin
            rd_count    = ch_count[rd_sel];
            rd_overflow = ch_ovf[rd_sel];
         end
      end
   end
`else
   logic unused_snapshot_req;
   assign unused_snapshot_req = snapshot_req;
   assign snap_valid          = 1'b0;

   always_comb begin
      rd_count    = '0;
      rd_overflow = 1'b0;
      if (int'(rd_sel) < NUM_CH) begin
         rd_count    = ch_count[rd_sel];
         rd_overflow = ch_ovf[rd_sel];
      end
   end
`endif

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// tb/tb_perf_event_counter_bank.sv - directed self-checking bench for perf_event_counter_bank
// Three instances share stimulus: 8x16 wrap, 5x4 wrap, 5x4 saturate.
module tb_perf_event_counter_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] event_in;
   logic       clear_all;
   logic       clear_ch;
   logic [2:0] clear_sel;
   logic [2:0] rd_sel;
   logic       snapshot_req;

   logic [15:0] a_count;
   logic        a_ovf, a_snap;
   logic [7:0]  a_vec;
   logic [3:0]  w_count;
   logic        w_ovf, w_snap;
   logic [4:0]  w_vec;
   logic [3:0]  s_count;
   logic        s_ovf, s_snap;
   logic [4:0]  s_vec;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   perf_event_counter_bank #(.NUM_CH(8), .WIDTH(16), .SATURATE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .event_in(event_in),
      .clear_all(clear_all), .clear_ch(clear_ch), .clear_sel(clear_sel),
      .rd_sel(rd_sel), .rd_count(a_count), .rd_overflow(a_ovf),
      .overflow_vec(a_vec), .snapshot_req(snapshot_req), .snap_valid(a_snap)
   );

   perf_event_counter_bank #(.NUM_CH(5), .WIDTH(4), .SATURATE(0)) u_w (
      .clk(clk), .rst_n(rst_n), .enable(enable), .event_in(event_in[4:0]),
      .clear_all(clear_all), .clear_ch(clear_ch), .clear_sel(clear_sel),
      .rd_sel(rd_sel), .rd_count(w_count), .rd_overflow(w_ovf),
      .overflow_vec(w_vec), .snapshot_req(snapshot_req), .snap_valid(w_snap)
   );

   perf_event_counter_bank #(.NUM_CH(5), .WIDTH(4), .SATURATE(1)) u_s (
      .clk(clk), .rst_n(rst_n), .enable(enable), .event_in(event_in[4:0]),
      .clear_all(clear_all), .clear_ch(clear_ch), .clear_sel(clear_sel),
      .rd_sel(rd_sel), .rd_count(s_count), .rd_overflow(s_ovf),
      .overflow_vec(s_vec), .snapshot_req(snapshot_req), .snap_valid(s_snap)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         event_in[ch] = 1'b1;
         tick();
         event_in[ch] = 1'b0;
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; event_in = '0;
      clear_all = 1'b0; clear_ch = 1'b0; clear_sel = '0;
      rd_sel = '0; snapshot_req = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      check("reset_count", a_count, 0);
      check("reset_ovf_vec", a_vec, 0);
      check("reset_snap_valid", a_snap, 0);

      // Test 1: one-cycle latency, then three pulses on ch0
      event_in[0] = 1'b1;
      tick();
      check("t1_latency", a_count, 1);
      event_in[0] = 1'b0;
      tick();
      pulse(0, 2);
      check("t1_ch0_count", a_count, 3);
      rd_sel = 3'd1;
      #1 check("t1_ch1_zero", a_count, 0);

      // Test 2: level held high counts once
      event_in[1] = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      check("t2_held_high", a_count, 1);
      event_in[1] = 1'b0;
      tick();
      event_in[1] = 1'b1;
      tick();
      check("t2_second_edge", a_count, 2);
      event_in[1] = 1'b0;
      tick();

      // Test 3: 16 edges on ch2
      rd_sel = 3'd2;
      pulse(2, 16);
      check("t3_w16_count", a_count, 16);
      check("t3_w16_ovf", a_ovf, 0);
      check("t3_wrap_count", w_count, 0);
      check("t3_wrap_ovf_vec", w_vec, 5'b00100);
      check("t3_sat_count", s_count, 15);
      check("t3_sat_ovf", s_ovf, 1);
      rd_sel = 3'd6;
      #1 check("t3_oor_count", a_count, 0);
      check("t3_oor_w_count", w_count, 0);
      clear_ch = 1'b1; clear_sel = 3'd6;
      tick();
      clear_ch = 1'b0;
      check("t3_oor_clear_noop", w_vec, 5'b00100);
      rd_sel = 3'd2;
      event_in[2] = 1'b1; clear_ch = 1'b1; clear_sel = 3'd2;
      tick();
      event_in[2] = 1'b0; clear_ch = 1'b0;
      check("t3_clr_edge_count", w_count, 0);
      check("t3_clr_edge_ovf", w_ovf, 0);
      check("t3_clr_a_count", a_count, 0);
      check("t3_clr_s_vec", s_vec, 0);
      rd_sel = 3'd0;
      #1 check("t3_ch0_untouched", a_count, 3);
      tick();

      // Test 4: 20 edges on ch2, then clear_all
      rd_sel = 3'd2;
      pulse(2, 20);
      check("t4_sat_count", s_count, 15);
      check("t4_sat_ovf", s_ovf, 1);
      check("t4_wrap_count", w_count, 4);
      check("t4_wrap_ovf", w_ovf, 1);
      check("t4_w16_count", a_count, 20);
      clear_all = 1'b1;
      tick();
      clear_all = 1'b0;
      check("t4_clrall_s_count", s_count, 0);
      check("t4_clrall_s_vec", s_vec, 0);
      check("t4_clrall_w_vec", w_vec, 0);
      rd_sel = 3'd0;
      #1 check("t4_clrall_ch0", a_count, 0);

      // Test 5: enable gating, held level across enable rise, async reset
      rd_sel = 3'd3;
      enable = 1'b0;
      pulse(3, 1);
      check("t5_disabled", a_count, 0);
      event_in[3] = 1'b1;
      tick();
      enable = 1'b1;
      tick();
      check("t5_held_across_enable", a_count, 0);
      event_in[3] = 1'b0;
      tick();
      rd_sel = 3'd0;
      pulse(0, 2);
      check("t5_pre_reset", a_count, 2);
      #2 rst_n = 1'b0;
      #1 check("t5_async_reset", a_count, 0);
      event_in[4] = 1'b1;
      tick();
      rst_n = 1'b1;
      rd_sel = 3'd4;
      tick();
      check("t5_high_after_reset", a_count, 1);
      check("t5_high_after_reset_w", w_count, 1);
      event_in[4] = 1'b0;
      tick();

      // Test 6: snapshot with a same-cycle edge on ch0
      rd_sel = 3'd0;
      pulse(0, 5);
      check("t6_ch0_five", a_count, 5);
      event_in[0] = 1'b1; snapshot_req = 1'b1;
      tick();
      event_in[0] = 1'b0; snapshot_req = 1'b0;
`ifdef PERF_CTR_SNAPSHOT_EN
      check("t6_snap_count", a_count, 5);
      check("t6_snap_valid", a_snap, 1);
      tick();
      clear_all = 1'b1;
      tick();
      clear_all = 1'b0;
      check("t6_snap_cleared", a_snap, 0);
      check("t6_count_cleared", a_count, 0);
`else
      check("t6_live_count", a_count, 6);
      check("t6_snap_valid_off", a_snap, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
